// File: rtl/mult_pkg.sv
// Shared definitions for the sequential MULTU unit: command codes, FSM states
// and the default operand width. The command codes are also used by the
// ALU/HI-LO control unit.
package mult_pkg;

   localparam int DEFAULT_WIDTH = 32;

   localparam logic [5:0] CMD_MULTU = 6'b011001;
   localparam logic [5:0] CMD_OUT   = 6'b111111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mult_step.sv
// One shift-and-add iteration of the unsigned multiplier. The low half of the
// product register holds the not-yet-consumed multiplier bits. The high half
// accumulates the partial product. The carry of the 33-bit add re-enters at
// bit 63 as everything shifts right by one.
module mult_step
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [2*WIDTH-1:0] product,
   input  logic [WIDTH-1:0]   mcand,
   output logic [2*WIDTH-1:0] product_next
);

   logic [WIDTH:0] sum_s;

   // Add the multiplicand when the current multiplier bit is set, then shift right
   always_comb begin
      sum_s = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
      if (product[0]) begin
         product_next = {sum_s, product[WIDTH-1:1]};
      end else begin
         product_next = {1'b0, product[2*WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/multiplier.sv
// Sequential unsigned WIDTH x WIDTH -> 2*WIDTH multiplier (MULTU unit).
// MULTU in IDLE loads the operands. WIDTH shift-add steps follow, one per clock.
// The FSM then waits in DONE until the command leaves MULTU, so holding MULTU
// runs exactly one multiply. OUT in IDLE or DONE copies the product register
// to the registered output. dataOut changes on nothing else except reset.
module multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     dataA,
   input  logic [WIDTH-1:0]     dataB,
   input  logic [5:0]           Signal,
   output logic [2*WIDTH-1:0]   dataOut
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e               state_r;
   state_e               state_next_s;
   logic [CNT_W-1:0]     counter_r;
   logic [2*WIDTH-1:0]   product_r;
   logic [WIDTH-1:0]     mcand_r;
   logic [2*WIDTH-1:0]   dataout_r;
   logic [2*WIDTH-1:0]   product_next_s;
   logic                 last_iter_s;
   logic                 load_s;
   logic                 step_s;
   logic                 capture_s;

   assign last_iter_s = (counter_r == CNT_W'(WIDTH - 1));

   mult_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .product      (product_r),
      .mcand        (mcand_r),
      .product_next (product_next_s)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (Signal == CMD_MULTU) begin
               state_next_s = BUSY;
            end else begin
               state_next_s = IDLE;
            end
         end
         BUSY: begin
            if (last_iter_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = BUSY;
            end
         end
         DONE: begin
            if (Signal == CMD_MULTU) begin
               state_next_s = DONE;
            end else begin
               state_next_s = IDLE;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Datapath controls decoded from the current state and command
   always_comb begin
      load_s    = 1'b0;
      step_s    = 1'b0;
      capture_s = 1'b0;
      case (state_r)
         IDLE: begin
            load_s    = (Signal == CMD_MULTU);
            capture_s = (Signal == CMD_OUT);
         end
         BUSY: begin
            step_s    = 1'b1;
         end
         DONE: begin
            capture_s = (Signal == CMD_OUT);
         end
         default: begin
            load_s    = 1'b0;
            step_s    = 1'b0;
            capture_s = 1'b0;
         end
      endcase
   end

   // Operand load and iteration of the product/counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand_r   <= '0;
         product_r <= '0;
         counter_r <= '0;
      end else if (load_s) begin
         mcand_r   <= dataA;
         product_r <= {{WIDTH{1'b0}}, dataB};
         counter_r <= '0;
      end else if (step_s) begin
         product_r <= product_next_s;
         counter_r <= counter_r + CNT_W'(1);
      end
   end

   // Registered result, updated only by OUT outside BUSY
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dataout_r <= '0;
      end else if (capture_s) begin
         dataout_r <= product_r;
      end
   end

   assign dataOut = dataout_r;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the MULTU unit. The expected products come from
// plain 64-bit arithmetic. The expected dataOut is tracked as "last product
// delivered by OUT since reset".
module tb_multiplier;

   localparam logic [5:0] C_MULTU = 6'b011001;
   localparam logic [5:0] C_OUT   = 6'b111111;
   localparam logic [5:0] C_NOP   = 6'b000000;

   logic        clk;
   logic        reset;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic [5:0]  Signal;
   logic [63:0] dataOut;

   int          n_tests;
   int          n_fail;
   logic [63:0] model_out;

   multiplier #(
      .WIDTH (32)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .dataA   (dataA),
      .dataB   (dataB),
      .Signal  (Signal),
      .dataOut (dataOut)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard bound on run time
   initial begin
      #400000;
      $display("FAIL timeout: got no finish, expected finish before 400000");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset asserted between edges; the output must clear without a clock edge
   task automatic async_reset(input string tag);
      #2;
      reset = 1'b0;
      #1;
      check(tag, dataOut, 64'd0);
      model_out = 64'd0;
      Signal = C_NOP;
      #1;
      reset = 1'b1;
      tick();
   endtask

   // Full multiply: MULTU held for 'hold' edges (optionally with OUT on edge
   // out_at, which falls inside BUSY), operands optionally scrambled after the
   // load edge, then OUT and a check of the delivered product.
   task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int hold, input bit scramble, input int out_at);
      logic [63:0] exp;
      exp   = 64'(a) * 64'(b);
      dataA = a;
      dataB = b;
      for (int e = 1; e <= hold; e++) begin
         Signal = (e == out_at) ? C_OUT : C_MULTU;
         tick();
         if (scramble && e == 1) begin
            dataA = $urandom;
            dataB = $urandom;
         end
         if (e == out_at) begin
            check({tag, "_busy_out"}, dataOut, model_out);
         end
      end
      Signal = C_OUT;
      tick();
      Signal = C_NOP;
      check(tag, dataOut, exp);
      model_out = exp;
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      int          hold;
      int          oat;
      n_tests   = 0;
      n_fail    = 0;
      model_out = 64'd0;
      reset     = 1'b0;
      Signal    = C_NOP;
      dataA     = 32'd0;
      dataB     = 32'd0;
      repeat (2) tick();
      check("reset_state", dataOut, 64'd0);
      reset = 1'b1;
      tick();

      // OUT before any multiply
      Signal = C_OUT;
      tick();
      Signal = C_NOP;
      check("out_before_mult", dataOut, 64'd0);

      // Nonzero result, then asynchronous reset, then OUT yields 0
      run_mult("mult_3x4", 32'd3, 32'd4, 33, 1'b0, 0);
      async_reset("async_reset");
      Signal = C_OUT;
      tick();
      Signal = C_NOP;
      check("out_after_reset", dataOut, 64'd0);

      // Basic multiply with MULTU held well past completion
      run_mult("mult_10x20", 32'd10, 32'd20, 40, 1'b0, 0);
      repeat (5) tick();
      check("hold_200", dataOut, 64'd200);

      // Reset between operations
      async_reset("reset_between");
      run_mult("mult_5x15", 32'd5, 32'd15, 40, 1'b0, 0);

      // Boundary operands at exact minimum latency
      run_mult("mult_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0, 0);
      run_mult("mult_msb_x2", 32'h8000_0000, 32'd2, 33, 1'b0, 0);
      run_mult("mult_zero_a", 32'd0, 32'hDEAD_BEEF, 33, 1'b0, 0);
      run_mult("mult_zero_b", 32'h1234_5678, 32'd0, 33, 1'b0, 0);

      // OUT during BUSY is ignored; operand changes during BUSY are ignored
      run_mult("out_at_11", 32'h0001_2345, 32'h0000_6789, 33, 1'b1, 11);
      run_mult("out_at_33", 32'hCAFE_F00D, 32'h0BAD_F00D, 36, 1'b1, 33);

      // Randomized multiplies
      for (int i = 0; i < 12; i++) begin
         ra   = $urandom;
         rb   = $urandom;
         if ($urandom_range(7, 0) == 0) ra = 32'd0;
         if ($urandom_range(7, 0) == 0) rb = 32'hFFFF_FFFF;
         hold = $urandom_range(45, 33);
         oat  = ($urandom_range(1, 0) == 1) ? $urandom_range(33, 2) : 0;
         run_mult("rand", ra, rb, hold, $urandom_range(1, 0) == 1, oat);
         repeat ($urandom_range(3, 0)) tick();
         check("rand_hold", dataOut, model_out);
      end

      // Reset in the middle of a multiply
      dataA  = 32'd9;
      dataB  = 32'd11;
      Signal = C_MULTU;
      repeat (15) tick();
      async_reset("mid_op_reset");
      Signal = C_OUT;
      tick();
      Signal = C_NOP;
      check("mid_op_out_zero", dataOut, 64'd0);
      run_mult("mult_7x6", 32'd7, 32'd6, 33, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multiplier.md
Name: multiplier

Overview:
- Sequential unsigned 32x32 -> 64-bit multiplier.
- Uses a shift-and-add datapath with one partial-product step per clock.
- Driven by a 6-bit command code from the ALU/HI-LO control path:
  - MULTU starts a multiply.
  - OUT copies the finished product to the registered output.
- Sits beside the ALU as the multi-cycle MULTU unit of the pipeline datapath.

Parameters:
- WIDTH, 32, operand width. dataOut is 2*WIDTH bits, and the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- dataA  input  32  multiplicand, unsigned.
- dataB  input  32  multiplier, unsigned.
- Signal  input  6  command code: 6'b011001 = MULTU, 6'b111111 = OUT, all other codes = no-op.
- dataOut  output  64  registered product output.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, counter=0, product register=0, multiplicand register=0, dataOut=0.
- State machine:
  - IDLE: if Signal==MULTU, load multiplicand<=dataA, product<={32'b0, dataB}, counter<=0, then go to BUSY. Otherwise stay in IDLE.
  - BUSY: one iteration per cycle.
    - If product[0]==1, compute sum = {1'b0, product[63:32]} + {1'b0, multiplicand}. This is a 33-bit add.
    - Then product <= {sum, product[31:1]}, i.e. shift right by one, with the carry entering bit 63.
    - If product[0]==0, product <= product >> 1.
    - counter increments each iteration. After the 32nd iteration (counter==31), go to DONE.
  - DONE: product holds the full 64-bit result. Stay in DONE while Signal==MULTU; return to IDLE on any other code.
  - Holding Signal at MULTU therefore runs exactly one multiply, not repeated ones.
- Latency: the load edge plus 32 iteration edges, so the product is final 33 rising edges after MULTU is first sampled in IDLE.
- Operands are sampled only on the load edge. Changes to dataA/dataB while BUSY or DONE are ignored.
- OUT command:
  - If Signal==OUT on a rising edge and state is IDLE or DONE, dataOut <= product, so dataOut is valid 1 cycle later.
  - OUT while BUSY is ignored; dataOut holds its value.
  - OUT issued before any multiply gives dataOut=0.
- dataOut changes only on OUT or reset; it otherwise holds its value indefinitely.
- MULTU issued while BUSY has no effect; it neither restarts nor aborts the multiply.
- Reset mid-multiply aborts immediately: all registers clear and dataOut goes to 0.
- No overflow is possible, because the 64-bit result covers the full unsigned range.
- Result examples: 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE00000001; either operand 0 gives 0.

Decomposition:
- Shared package mult_pkg holds:
  - CMD_MULTU=6'b011001 and CMD_OUT=6'b111111 (localparams, also used by the control unit).
  - State enum {IDLE, BUSY, DONE}.
  - Default WIDTH=32.
- Optional sub-module mult_step: combinational single shift-add iteration, taking the 64-bit product and 32-bit multiplicand and returning the next 64-bit product. The top level holds the FSM, counter and registers.

Test Plan:
- Async reset: assert reset=0 mid-cycle -> dataOut==0 immediately, without waiting for a clock edge. Release, then issue OUT -> dataOut stays 0.
- Basic multiply: reset=1, dataA=10, dataB=20, Signal=MULTU held for 40 cycles, then Signal=OUT -> dataOut==200 one cycle after OUT, and it stays 200 afterwards.
- Reset between operations:
  - After the previous test, reset=0 -> dataOut==0.
  - Release, then dataA=5, dataB=15, MULTU for 40 cycles, then OUT -> dataOut==75.
- Max operands: dataA=dataB=0xFFFFFFFF, MULTU for 33 cycles, then OUT -> dataOut==64'hFFFFFFFE00000001.
  - Also check that 0x80000000*2 gives 0x100000000.
- Timing/robustness:
  - Issue OUT after only 10 cycles of MULTU -> dataOut unchanged (BUSY).
  - Change dataA/dataB during BUSY -> the result uses the operands loaded at start.
  - MULTU for exactly 33 cycles, then OUT -> correct product.
- Mid-op reset: reset=0 at cycle 15 of a multiply -> dataOut==0.
  - Then a fresh 7*6 multiply -> dataOut==42.
